// File: rtl/multdiv_ctrl_if.sv
// Bundle between the execute-stage sequencer, the X stage, the mul/div unit and writeback.
// The sequencer takes the slave side; the surrounding pipeline/environment takes master.
interface multdiv_ctrl_if;
  logic        flush;
  logic        in_valid;
  logic        in_is_div;
  logic [31:0] in_opA;
  logic [31:0] in_opB;
  logic [4:0]  in_rd;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] md_operandA;
  logic [31:0] md_operandB;
  logic [31:0] md_result;
  logic        md_exception;
  logic        md_resultRDY;
  logic        stall;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  modport slave (
    input  flush, in_valid, in_is_div, in_opA, in_opB, in_rd,
    input  md_result, md_exception, md_resultRDY,
    output ctrl_MULT, ctrl_DIV, md_operandA, md_operandB,
    output stall, wb_valid, wb_rd, wb_data
  );

  modport master (
    output flush, in_valid, in_is_div, in_opA, in_opB, in_rd,
    output md_result, md_exception, md_resultRDY,
    input  ctrl_MULT, ctrl_DIV, md_operandA, md_operandB,
    input  stall, wb_valid, wb_rd, wb_data
  );
endinterface

// File: rtl/multdiv_ctrl.sv
// Execute-stage sequencer for the iterative multiply/divide unit: latches one op, strobes
// the unit, stalls the pipeline until RDY or timeout, then issues a single writeback.
//
//   state   | meaning
//   S_IDLE  | waiting for a mul/div in X; stall follows in_valid
//   S_START | one-cycle start strobe to the unit; stale RDY ignored
//   S_BUSY  | counting cycles until RDY or timeout
//   S_DONE  | writeback cycle, pipeline released
module multdiv_ctrl #(
  parameter int TIMEOUT = 64,
  parameter int MUL_EXC = 4,
  parameter int DIV_EXC = 5
) (
  input  logic          clock,
  input  logic          rst_n,
  multdiv_ctrl_if.slave bus
);
  localparam int            CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [4:0]    RSTATUS  = 5'd30;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_BUSY  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_op_a;
  logic [31:0]   r_op_b;
  logic [4:0]    r_rd;
  logic          r_is_div;
  logic          r_stb_mul;
  logic          r_stb_div;
  logic          r_wb_valid;
  logic [4:0]    r_wb_rd;
  logic [31:0]   r_wb_data;

  logic [31:0]   w_exc_code;
  logic          w_stall;

  assign w_exc_code = r_is_div ? 32'(DIV_EXC) : 32'(MUL_EXC);

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_op_a     <= '0;
      r_op_b     <= '0;
      r_rd       <= '0;
      r_is_div   <= 1'b0;
      r_stb_mul  <= 1'b0;
      r_stb_div  <= 1'b0;
      r_wb_valid <= 1'b0;
      r_wb_rd    <= '0;
      r_wb_data  <= '0;
    end else begin
      // Strobes and writeback are single-cycle; they are only set on entry to START/DONE.
      r_stb_mul  <= 1'b0;
      r_stb_div  <= 1'b0;
      r_wb_valid <= 1'b0;
      r_wb_rd    <= '0;
      r_wb_data  <= '0;

      if (bus.flush) begin
        r_state <= S_IDLE;
        r_cnt   <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (bus.in_valid) begin
              r_op_a    <= bus.in_opA;
              r_op_b    <= bus.in_opB;
              r_rd      <= bus.in_rd;
              r_is_div  <= bus.in_is_div;
              r_stb_mul <= ~bus.in_is_div;
              r_stb_div <= bus.in_is_div;
              r_state   <= S_START;
            end
          end

          S_START: begin
            r_cnt   <= '0;
            r_state <= S_BUSY;
          end

          S_BUSY: begin
            r_cnt <= r_cnt + CW'(1);
            if (bus.md_resultRDY) begin
              r_state <= S_DONE;
              if (bus.md_exception) begin
                r_wb_valid <= 1'b1;
                r_wb_rd    <= RSTATUS;
                r_wb_data  <= w_exc_code;
              end else begin
                // A result aimed at r0 completes silently.
                r_wb_valid <= (r_rd != 5'd0);
                r_wb_rd    <= r_rd;
                r_wb_data  <= bus.md_result;
              end
            end else if (r_cnt == CNT_LAST) begin
              r_state    <= S_DONE;
              r_wb_valid <= 1'b1;
              r_wb_rd    <= RSTATUS;
              r_wb_data  <= w_exc_code;
            end
          end

          S_DONE: begin
            r_state <= S_IDLE;
          end

          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  always_comb begin
    w_stall = 1'b1;
    case (r_state)
      S_IDLE:  w_stall = bus.in_valid;
      S_DONE:  w_stall = 1'b0;
      default: w_stall = 1'b1;
    endcase
  end

  // A flush in the strobe or writeback cycle must kill the pulse in that same cycle.
  assign bus.ctrl_MULT   = r_stb_mul & ~bus.flush;
  assign bus.ctrl_DIV    = r_stb_div & ~bus.flush;
  assign bus.wb_valid    = r_wb_valid & ~bus.flush;
  assign bus.wb_rd       = r_wb_rd;
  assign bus.wb_data     = r_wb_data;
  assign bus.md_operandA = r_op_a;
  assign bus.md_operandB = r_op_b;
  assign bus.stall       = w_stall;
endmodule

// File: tb/tb_multdiv_ctrl.sv
// Self-checking bench for multdiv_ctrl: directed scenarios plus randomized back-to-back ops,
// each checked against a cycle-count reference model of the sequencer's rules.
module tb_multdiv_ctrl;
  localparam int TIMEOUT = 64;
  localparam int MUL_EXC = 4;
  localparam int DIV_EXC = 5;

  logic clock = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  multdiv_ctrl_if bus ();

  multdiv_ctrl #(
    .TIMEOUT (TIMEOUT),
    .MUL_EXC (MUL_EXC),
    .DIV_EXC (DIV_EXC)
  ) dut (
    .clock (clock),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit          is_div;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    int          rdy_at;
    bit          exc;
    logic [31:0] res;
    bit          stale;
  } op_t;

  // Cycle 0 = accept, cycle 1 = strobe; RDY counts from cycle 2 to TIMEOUT+1.
  function automatic void model(input op_t op, output int e_done, output int e_wb,
                                output logic [4:0] e_rd, output logic [31:0] e_data);
    bit timeout;
    timeout = (op.rdy_at < 2) || (op.rdy_at > TIMEOUT + 1);
    e_done  = timeout ? TIMEOUT + 2 : op.rdy_at + 1;
    if (timeout || op.exc) begin
      e_wb   = 1;
      e_rd   = 5'd30;
      e_data = op.is_div ? 32'(DIV_EXC) : 32'(MUL_EXC);
    end else begin
      e_wb   = (op.rd != 5'd0) ? 1 : 0;
      e_rd   = op.rd;
      e_data = op.res;
    end
  endfunction

  task automatic drive_op(input op_t op, output int done_cyc, output int n_mul, output int n_div,
                          output int stb_cyc, output int n_stall, output int n_wb,
                          output logic [4:0] o_rd, output logic [31:0] o_data,
                          output bit opnd_ok, output int n_leak);
    bit is_done;
    done_cyc = -1; n_mul = 0; n_div = 0; stb_cyc = -1; n_stall = 0; n_wb = 0;
    o_rd = '0; o_data = '0; opnd_ok = 1'b1; n_leak = 0;
    for (int c = 0; c < 100 && done_cyc < 0; c++) begin
      @(posedge clock); #1;
      bus.flush        = 1'b0;
      bus.in_valid     = 1'b1;
      bus.in_is_div    = op.is_div;
      bus.in_opA       = (c == 0) ? op.a : $urandom;
      bus.in_opB       = (c == 0) ? op.b : $urandom;
      bus.in_rd        = (c == 0) ? op.rd : 5'($urandom);
      bus.md_resultRDY = (op.stale && c <= 1) || (c == op.rdy_at);
      bus.md_exception = (c == op.rdy_at) ? op.exc : (op.stale && c <= 1);
      bus.md_result    = (c == op.rdy_at) ? op.res : $urandom;
      @(negedge clock);
      is_done = (c > 0) && !bus.stall;
      if (bus.stall) n_stall++;
      if (bus.ctrl_MULT) begin n_mul++; stb_cyc = c; end
      if (bus.ctrl_DIV)  begin n_div++; stb_cyc = c; end
      if (c >= 1 && (bus.md_operandA !== op.a || bus.md_operandB !== op.b)) opnd_ok = 1'b0;
      if (is_done) begin
        done_cyc = c;
        o_rd     = bus.wb_rd;
        o_data   = bus.wb_data;
        if (bus.wb_valid) n_wb++;
      end else if (bus.wb_valid || bus.wb_rd != 0 || bus.wb_data != 0) begin
        n_leak++;
      end
    end
  endtask

  task automatic test_reset();
    bus.flush = 0; bus.in_valid = 1; bus.in_is_div = 0; bus.in_opA = 32'hAAAA5555;
    bus.in_opB = 32'h12345678; bus.in_rd = 5'd9; bus.md_result = 0;
    bus.md_exception = 0; bus.md_resultRDY = 0;
    rst_n = 1'b0;
    repeat (3) @(posedge clock);
    #1 bus.in_valid = 0;
    @(negedge clock);
    n_cmp++;
    if ({bus.stall, bus.ctrl_MULT, bus.ctrl_DIV, bus.wb_valid} !== 4'b0) begin
      n_err++; $display("FAIL reset_ctl: got %b want 0000",
                        {bus.stall, bus.ctrl_MULT, bus.ctrl_DIV, bus.wb_valid});
    end
    n_cmp++;
    if ({bus.wb_rd, bus.wb_data, bus.md_operandA, bus.md_operandB} !== '0) begin
      n_err++; $display("FAIL reset_data: got rd=%0d data=%h A=%h B=%h want all 0",
                        bus.wb_rd, bus.wb_data, bus.md_operandA, bus.md_operandB);
    end
    @(posedge clock); #1 rst_n = 1'b1;
    @(negedge clock);
    n_cmp++;
    if ({bus.stall, bus.ctrl_MULT, bus.ctrl_DIV} !== 3'b0) begin
      n_err++; $display("FAIL reset_release: got %b want 000",
                        {bus.stall, bus.ctrl_MULT, bus.ctrl_DIV});
    end
  endtask

  task automatic test_directed();
    op_t ops[5];
    int d, nm, nd, sc, ns, nw, nl, e_done, e_wb;
    logic [4:0] ord, e_rd;
    logic [31:0] odata, e_data;
    bit ok;
    ops[0] = '{0, 32'd7,   32'd6, 5'd3,  17, 0, 32'd42,        0};
    ops[1] = '{1, 32'd100, 32'd0, 5'd4,   9, 1, 32'hDEADBEEF,  0};
    ops[2] = '{0, 32'd3,   32'd5, 5'd0,   6, 0, 32'h1234,      0};
    ops[3] = '{0, 32'd9,   32'd9, 5'd12, 10, 0, 32'd81,        1};
    ops[4] = '{0, 32'd5,   32'd5, 5'd8,  -1, 0, 32'd25,        0};
    for (int i = 0; i < 5; i++) begin
      model(ops[i], e_done, e_wb, e_rd, e_data);
      drive_op(ops[i], d, nm, nd, sc, ns, nw, ord, odata, ok, nl);
      n_cmp++;
      if (d !== e_done) begin n_err++; $display("FAIL dir%0d done_cycle: got %0d want %0d", i, d, e_done); end
      n_cmp++;
      if (ns !== e_done) begin n_err++; $display("FAIL dir%0d stall_cycles: got %0d want %0d", i, ns, e_done); end
      n_cmp++;
      if (nm !== (ops[i].is_div ? 0 : 1) || nd !== (ops[i].is_div ? 1 : 0) || sc !== 1) begin
        n_err++; $display("FAIL dir%0d strobes: got mul=%0d div=%0d at %0d want one at 1", i, nm, nd, sc);
      end
      n_cmp++;
      if (nw !== e_wb) begin n_err++; $display("FAIL dir%0d wb_valid: got %0d want %0d", i, nw, e_wb); end
      if (e_wb == 1) begin
        n_cmp++;
        if (ord !== e_rd || odata !== e_data) begin
          n_err++; $display("FAIL dir%0d wb: got rd=%0d data=%h want rd=%0d data=%h", i, ord, odata, e_rd, e_data);
        end
      end
      n_cmp++;
      if (!ok || nl !== 0) begin n_err++; $display("FAIL dir%0d hold: got opnd_ok=%0d leaks=%0d want 1/0", i, ok, nl); end
      @(posedge clock); #1 bus.in_valid = 0; bus.md_resultRDY = 0;
      @(negedge clock);
      n_cmp++;
      if ({bus.stall, bus.ctrl_MULT, bus.ctrl_DIV, bus.wb_valid} !== 4'b0) begin
        n_err++; $display("FAIL dir%0d idle_after: got %b want 0000", i,
                          {bus.stall, bus.ctrl_MULT, bus.ctrl_DIV, bus.wb_valid});
      end
    end
  endtask

  task automatic test_flush_reset();
    // flush in BUSY (cycle 5), the unit's late RDY must be ignored
    for (int c = 0; c < 9; c++) begin
      @(posedge clock); #1;
      bus.in_valid = (c <= 5); bus.in_is_div = 0; bus.in_rd = 5'd7;
      bus.in_opA = 32'h11111111; bus.in_opB = 32'h22222222;
      bus.flush = (c == 5);
      bus.md_resultRDY = (c == 7 || c == 8); bus.md_exception = (c == 7); bus.md_result = 32'h55;
      @(negedge clock);
      if (c == 1) begin
        n_cmp++;
        if (bus.ctrl_MULT !== 1'b1) begin n_err++; $display("FAIL flush_strobe: got %b want 1", bus.ctrl_MULT); end
      end
      if (c >= 6) begin
        n_cmp++;
        if ({bus.stall, bus.wb_valid, bus.ctrl_MULT, bus.ctrl_DIV} !== 4'b0) begin
          n_err++; $display("FAIL flush_busy c%0d: got %b want 0000", c,
                            {bus.stall, bus.wb_valid, bus.ctrl_MULT, bus.ctrl_DIV});
        end
      end
    end
    // flush in START suppresses the strobe in that cycle
    for (int c = 0; c < 4; c++) begin
      @(posedge clock); #1;
      bus.in_valid = (c <= 1); bus.flush = (c == 1); bus.md_resultRDY = 0; bus.md_exception = 0;
      @(negedge clock);
      n_cmp++;
      if (c >= 1 && {bus.ctrl_MULT, bus.ctrl_DIV, bus.wb_valid} !== 3'b0) begin
        n_err++; $display("FAIL flush_start c%0d: got %b want 000", c, {bus.ctrl_MULT, bus.ctrl_DIV, bus.wb_valid});
      end else if (c >= 2 && bus.stall !== 1'b0) begin
        n_err++; $display("FAIL flush_start_stall c%0d: got %b want 0", c, bus.stall);
      end
    end
    // reset in START (with flush also high) clears everything
    for (int c = 0; c < 4; c++) begin
      @(posedge clock); #1;
      bus.in_valid = (c == 0); bus.in_is_div = 1;
      bus.in_opA = 32'hCAFE0001; bus.in_opB = 32'hCAFE0002;
      rst_n = (c != 1); bus.flush = (c == 1);
      @(negedge clock);
      if (c >= 2) begin
        n_cmp++;
        if ({bus.stall, bus.ctrl_MULT, bus.ctrl_DIV, bus.wb_valid, bus.wb_rd, bus.wb_data,
             bus.md_operandA, bus.md_operandB} !== '0) begin
          n_err++; $display("FAIL reset_start c%0d: got stall=%b A=%h B=%h wb=%b want all 0", c,
                            bus.stall, bus.md_operandA, bus.md_operandB, bus.wb_valid);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    op_t op;
    int d, nm, nd, sc, ns, nw, nl, e_done, e_wb, r;
    logic [4:0] ord, e_rd;
    logic [31:0] odata, e_data;
    bit ok;
    for (int i = 0; i < 25; i++) begin
      r         = $urandom_range(0, 9);
      op.is_div = $urandom_range(0, 1);
      op.a      = $urandom;
      op.b      = $urandom;
      op.rd     = 5'($urandom_range(0, 31));
      op.rdy_at = (r == 0) ? -1 : (r == 1) ? TIMEOUT + 1 : $urandom_range(2, 30);
      op.exc    = ($urandom_range(0, 3) == 0);
      op.res    = $urandom;
      op.stale  = ($urandom_range(0, 3) == 0);
      model(op, e_done, e_wb, e_rd, e_data);
      drive_op(op, d, nm, nd, sc, ns, nw, ord, odata, ok, nl);
      n_cmp++;
      if (d !== e_done || ns !== e_done) begin
        n_err++; $display("FAIL rnd%0d timing: got done=%0d stall=%0d want %0d", i, d, ns, e_done);
      end
      n_cmp++;
      if (nm !== (op.is_div ? 0 : 1) || nd !== (op.is_div ? 1 : 0) || sc !== 1) begin
        n_err++; $display("FAIL rnd%0d strobes: got mul=%0d div=%0d at %0d", i, nm, nd, sc);
      end
      n_cmp++;
      if (nw !== e_wb || (e_wb == 1 && (ord !== e_rd || odata !== e_data))) begin
        n_err++; $display("FAIL rnd%0d wb: got v=%0d rd=%0d data=%h want v=%0d rd=%0d data=%h",
                          i, nw, ord, odata, e_wb, e_rd, e_data);
      end
      n_cmp++;
      if (!ok || nl !== 0) begin n_err++; $display("FAIL rnd%0d hold: got opnd_ok=%0d leaks=%0d", i, ok, nl); end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_directed();
    test_flush_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
